// File: rtl/x_delay_line_tdc.sv
// x_delay_line_tdc: toggle-launched delay-line TDC with resynchronised tap capture
// and burst sum/min/max statistics on a valid/ready result port.
module x_delay_line_cell (
    input  logic a,
    output logic y
);
    assign y = a;
endmodule

module x_delay_line_tdc #(
    parameter int LENGTH   = 32,
    parameter int SYNC     = 2,
    parameter int AVG_LOG2 = 2,
    localparam int CW      = $clog2(LENGTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_cont,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [CW+AVG_LOG2-1:0] o_sum,
    output logic [CW-1:0]          o_min,
    output logic [CW-1:0]          o_max,
    output logic                   o_ovf,
    output logic [LENGTH-1:0]      o_raw
);
    localparam int SUMW = CW + AVG_LOG2;
    localparam int NW   = AVG_LOG2 + 1;
    localparam int TW   = $clog2(SYNC + 1);
    localparam logic [NW-1:0] LAST = NW'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, ENCODE, DONE} state_t;

    state_t              state, state_nxt;
    logic                launch;
    logic [LENGTH-1:0]   dl, sync_in, raw;
    logic [LENGTH-1:0]   sync_q [SYNC];
    logic [TW-1:0]       settle;
    logic [NW-1:0]       samp;
    logic [CW-1:0]       count;
    logic                run, clr;

    assign dl[0] = launch;
    for (genvar g = 0; g < LENGTH - 1; g++) begin : g_cell
        (* keep *) x_delay_line_cell u_cell (.a(dl[g]), .y(dl[g+1]));
    end
    assign sync_in = dl;
    assign raw     = sync_q[SYNC-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= sync_in;
            for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Run length from tap 0 makes the code independent of launch polarity.
    always_comb begin
        count = '0;
        run   = 1'b1;
        for (int i = 0; i < LENGTH; i++) begin
            run   = run & (raw[i] == raw[0]);
            count = count + CW'(run);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = i_start ? LAUNCH : IDLE;
            LAUNCH:  state_nxt = SETTLE;
            SETTLE:  state_nxt = (settle == '0) ? ENCODE : SETTLE;
            ENCODE:  state_nxt = (samp == LAST) ? DONE : LAUNCH;
            DONE:    state_nxt = i_ready ? (i_cont ? LAUNCH : IDLE) : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign clr     = (state == IDLE && i_start) || (state == DONE && i_ready && i_cont);
    assign o_busy  = state != IDLE;
    assign o_valid = state == DONE;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            launch <= 1'b0;
            settle <= '0;
            samp   <= '0;
            o_sum  <= '0;
            o_min  <= '0;
            o_max  <= '0;
            o_ovf  <= 1'b0;
            o_raw  <= '0;
        end else begin
            state <= state_nxt;
            if (state == LAUNCH) begin
                launch <= ~launch;
                settle <= TW'(SYNC - 1);
            end
            if (state == SETTLE && settle != '0) settle <= settle - TW'(1);
            if (clr) begin
                o_sum <= '0;
                o_min <= '1;
                o_max <= '0;
                o_ovf <= 1'b0;
                samp  <= '0;
            end else if (state == ENCODE) begin
                o_sum <= o_sum + SUMW'(count);
                o_min <= (count < o_min) ? count : o_min;
                o_max <= (count > o_max) ? count : o_max;
                o_ovf <= o_ovf | (count == CW'(LENGTH));
                o_raw <= raw;
                samp  <= samp + NW'(1);
            end
        end
    end
endmodule

// File: tb/tb_x_delay_line_tdc.sv
// tb_x_delay_line_tdc: directed checks of single-sample and burst TDC instances
// with forced tap vectors standing in for real delay-line timing.
module tb_x_delay_line_tdc;
    logic        clk = 1'b0, rst = 1'b1;
    logic        start_a = 1'b0, cont_a = 1'b0, ready_a = 1'b0;
    logic        start_b = 1'b0, cont_b = 1'b0, ready_b = 1'b0;
    logic        busy_a, valid_a, ovf_a, busy_b, valid_b, ovf_b;
    logic [5:0]  sum_a, min_a, max_a, min_b, max_b;
    logic [7:0]  sum_b;
    logic [31:0] raw_a, raw_b;
    logic [31:0] va = '0, vb = '0;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    x_delay_line_tdc #(.LENGTH(32), .SYNC(2), .AVG_LOG2(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_cont(cont_a), .i_ready(ready_a),
        .o_busy(busy_a), .o_valid(valid_a), .o_sum(sum_a), .o_min(min_a), .o_max(max_a),
        .o_ovf(ovf_a), .o_raw(raw_a)
    );

    x_delay_line_tdc #(.LENGTH(32), .SYNC(2), .AVG_LOG2(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_cont(cont_b), .i_ready(ready_b),
        .o_busy(busy_b), .o_valid(valid_b), .o_sum(sum_b), .o_min(min_b), .o_max(max_b),
        .o_ovf(ovf_b), .o_raw(raw_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic [31:0] v);
        va = v;
        force u_a.sync_in = va;
    endtask

    task automatic set_b(input logic [31:0] v);
        vb = v;
        force u_b.sync_in = vb;
    endtask

    task automatic run_a(input string tag, input logic [31:0] v, input int cnt, input logic ov);
        int n;
        set_a(v);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!valid_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd4);
        chk({tag, "_sum"}, 64'(sum_a), 64'(cnt));
        chk({tag, "_min"}, 64'(min_a), 64'(cnt));
        chk({tag, "_max"}, 64'(max_a), 64'(cnt));
        chk({tag, "_ovf"}, 64'(ovf_a), 64'(ov));
        chk({tag, "_raw"}, 64'(raw_a), 64'(v));
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        chk({tag, "_idle"}, 64'(busy_a), 64'd0);
    endtask

    initial begin
        int n, tog;
        logic prev;
        set_a(32'h0);
        set_b(32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy_b", 64'(busy_b), 64'd0);
        chk("rst_sum_b", 64'(sum_b), 64'd0);

        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_busy", 64'(busy_b), 64'd0);
        chk("mid_rst_valid", 64'(valid_b), 64'd0);
        chk("mid_rst_outs", {sum_b, min_b, max_b, 7'(ovf_b)}, 64'd0);
        chk("mid_rst_raw", 64'(raw_b), 64'd0);
        chk("mid_rst_launch", 64'(u_b.launch), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_launch", 64'(u_b.launch), 64'd0);
        chk("post_rst_busy", 64'(busy_b), 64'd0);

        run_a("t0_ff", 32'h0000_00FF, 8, 1'b0);
        run_a("t0_inv", 32'hFFFF_FF00, 8, 1'b0);
        run_a("sat", 32'hFFFF_FFFF, 32, 1'b1);
        run_a("bubble", 32'h0000_00F5, 1, 1'b0);

        set_b(32'h0000_0007);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        tog = 0;
        prev = u_b.launch;
        while (!valid_b && n < 100) begin
            @(negedge clk);
            n++;
            if (u_b.launch != prev) tog++;
            prev = u_b.launch;
            if (n == 4) set_b(32'hFFFF_FFE0);
            if (n == 8) set_b(32'h0000_007F);
            if (n == 12) set_b(32'h0000_01FF);
        end
        chk("burst_lat", 64'(n), 64'd16);
        chk("burst_toggles", 64'(tog), 64'd4);
        chk("burst_sum", 64'(sum_b), 64'd24);
        chk("burst_min", 64'(min_b), 64'd3);
        chk("burst_max", 64'(max_b), 64'd9);
        chk("burst_ovf", 64'(ovf_b), 64'd0);
        chk("burst_raw", 64'(raw_b), 64'h1FF);

        start_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(valid_b), 64'd1);
            chk("hold_sum", 64'(sum_b), 64'd24);
        end
        chk("hold_minmax", {min_b, max_b}, {6'd3, 6'd9});
        start_b = 1'b0;
        set_b(32'h0000_00FF);
        cont_b = 1'b1;
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
        cont_b = 1'b0;
        chk("cont_busy", 64'(busy_b), 64'd1);
        chk("cont_valid", 64'(valid_b), 64'd0);
        chk("cont_clr_sum", 64'(sum_b), 64'd0);
        chk("cont_clr_min", 64'(min_b), 64'h3F);
        n = 0;
        while (!valid_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cont_lat", 64'(n), 64'd16);
        chk("cont_sum", 64'(sum_b), 64'd32);
        chk("cont_minmax", {min_b, max_b}, {6'd8, 6'd8});
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
        chk("ack_idle", 64'(busy_b), 64'd0);
        chk("ack_valid", 64'(valid_b), 64'd0);
        repeat (3) @(negedge clk);
        chk("stay_idle", 64'(busy_b), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
